// File: rtl/hex_scan_display.sv
// Time-multiplexed hex driver for common-anode 7-segment banks: one digit per slot,
// double-buffered value, leading-zero blanking, per-digit blink, decimal points, dead time.
module hex_scan_display #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYC     = 64,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYC);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] LAST_FRM = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [FW-1:0]           frame_cnt;
   logic                    phase;
   logic [4*NUM_DIGITS-1:0] active;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pend;

   logic                    tick;
   logic                    boundary;
   logic [3:0]              cur_nib;
   logic [NUM_DIGITS:0]     zero_from;
   logic [NUM_DIGITS-1:0]   lz;
   logic                    blank;
   logic [NUM_DIGITS-1:0]   an_next;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_to_seg = 7'h40;
         4'h1: hex_to_seg = 7'h79;
         4'h2: hex_to_seg = 7'h24;
         4'h3: hex_to_seg = 7'h30;
         4'h4: hex_to_seg = 7'h19;
         4'h5: hex_to_seg = 7'h12;
         4'h6: hex_to_seg = 7'h02;
         4'h7: hex_to_seg = 7'h78;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h18;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h03;
         4'hC: hex_to_seg = 7'h46;
         4'hD: hex_to_seg = 7'h21;
         4'hE: hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   assign tick     = (cnt == LAST_CNT);
   assign boundary = tick && (idx == LAST_IDX);
   assign cur_nib  = active[4*idx +: 4];

   // zero_from[i] is set when every active nibble from digit i upward is zero
   always_comb begin
      zero_from = '1;
      lz        = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (active[4*i +: 4] == 4'd0);
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         lz[i] = blank_lz && zero_from[i];
      end
   end

   assign blank = lz[idx] || (blink_mask[idx] && phase);

   always_comb begin
      an_next = '1;
      if (cnt >= DEAD) an_next[idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt        <= '0;
         idx        <= '0;
         frame_cnt  <= '0;
         phase      <= 1'b0;
         active     <= '0;
         pending    <= '0;
         pend       <= 1'b0;
         seg_n      <= 7'h7F;
         dp_n       <= 1'b1;
         an_n       <= '1;
         frame_done <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

         if (load) pending <= value;
         // A load landing on the boundary bypasses the pending buffer
         if (boundary) begin
            if (load)      active <= value;
            else if (pend) active <= pending;
            pend <= 1'b0;
            if (frame_cnt == LAST_FRM) begin
               frame_cnt <= '0;
               phase     <= ~phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end else if (load) begin
            pend <= 1'b1;
         end

         an_n       <= an_next;
         seg_n      <= blank ? 7'h7F : hex_to_seg(cur_nib);
         dp_n       <= blank || !dp[idx];
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
// Randomized bench for hex_scan_display comparing every output each cycle against
// a frame/slot arithmetic model of the display.
module tb_hex_scan_display;

   localparam int N  = 4;
   localparam int S  = 16;
   localparam int D  = 2;
   localparam int BF = 2;
   localparam int SN = S * N;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  dp = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  blink_mask = '0;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_done;

   int total = 0;
   int bad = 0;
   int t_pos = 0;
   int          load_pos[$];
   logic [15:0] load_val[$];
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_scan_display #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp(dp),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .seg_n(seg_n), .dp_n(dp_n),
      .an_n(an_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (pos %0d, time %0t)", tag, got, exp, t_pos, $time);
      end
   endtask

   // Frame f shows the most recent load made before the frame began
   function automatic logic [15:0] active_for(input int f);
      logic [15:0] a = '0;
      foreach (load_pos[i]) if (load_pos[i] < f * SN) a = load_val[i];
      return a;
   endfunction

   task automatic cycle();
      logic r_rst, r_load, r_blz;
      logic [15:0] r_val, act;
      logic [3:0] r_dp, r_bm, nib, e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fd, blank, lzb, ph;
      int p, f, d, off;
      @(posedge clk);
      r_rst = reset_n; r_load = load; r_val = value;
      r_dp = dp; r_bm = blink_mask; r_blz = blank_lz;
      @(negedge clk);
      if (!r_rst) begin
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
         t_pos = 0;
         load_pos.delete();
         load_val.delete();
      end else begin
         p   = t_pos;
         f   = p / SN;
         d   = (p / S) % N;
         off = p % S;
         act = active_for(f);
         nib = act[4*d +: 4];
         lzb = r_blz && (d != 0) && ((act >> (4 * d)) == 16'd0);
         ph  = ((f / BF) % 2) == 1;
         blank = lzb || (r_bm[d] && ph);
         e_seg = blank ? 7'h7F : seg_tab[nib];
         e_dp  = blank ? 1'b1 : !r_dp[d];
         e_an  = 4'hF;
         if (off >= D) e_an[d] = 1'b0;
         e_fd  = (p % SN) == (SN - 1);
         if (r_load) begin
            load_pos.push_back(p);
            load_val.push_back(r_val);
         end
         t_pos++;
      end
      check("seg_n", 32'(seg_n), 32'(e_seg));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("an_n", 32'(an_n), 32'(e_an));
      check("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic load_value(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      cycle();
      load  = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      run(3);
      reset_n = 1'b1;
      run(2 * SN);

      // mid-frame load must wait for the next frame
      run(20);
      load_value(16'h12AF);
      run(3 * SN);

      blank_lz = 1'b1;
      load_value(16'h0050);
      run(2 * SN);
      load_value(16'h0000);
      run(2 * SN);
      blank_lz = 1'b0;

      blink_mask = 4'b0010;
      load_value(16'h4321);
      run(5 * SN);
      blink_mask = 4'b0000;

      // pending load then a load exactly on the boundary, which must win
      run(10);
      load_value(16'hA5A5);
      while ((t_pos % SN) != (SN - 1)) cycle();
      load_value(16'hBEEF);
      run(SN);

      repeat (1500) begin
         if ($urandom_range(0, 29) == 0) begin
            value = 16'($urandom);
            load  = 1'b1;
         end
         if ($urandom_range(0, 149) == 0) dp = 4'($urandom);
         if ($urandom_range(0, 199) == 0) blank_lz = 1'($urandom);
         if ($urandom_range(0, 199) == 0) blink_mask = 4'($urandom);
         cycle();
         load = 1'b0;
      end
      blank_lz = 1'b0;
      blink_mask = 4'b0000;

      dp = 4'b0100;
      load_value(16'h3210);
      run(2 * SN);
      run(S + 5);
      reset_n = 1'b0;
      run(2);
      reset_n = 1'b1;
      run(SN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
